// File: rtl/i2c_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared I2C master.
// Latches the winning command, issues it, waits for completion or timeout, and answers the requester.
module i2c_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [13:0] addr,
    input  logic [1:0]  rw,
    input  logic [15:0] wdata,
    output logic [1:0]  done,
    output logic [1:0]  err,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        m_start,
    output logic [6:0]  m_addr,
    output logic        m_rw,
    output logic [7:0]  m_wdata,
    input  logic        m_done,
    input  logic [7:0]  m_rdata,
    input  logic        m_nack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] timer;
    logic        gnt;
    logic        last_grant;
    logic        pick;

    // On a tie the requester that was not served last wins.
    always_comb begin
        pick = req[1];
        if (req == 2'b11) begin
            pick = ~last_grant;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            timer      <= 16'd0;
            gnt        <= 1'b0;
            last_grant <= 1'b1;
            done       <= 2'b00;
            err        <= 2'b00;
            rdata      <= 8'd0;
            busy       <= 1'b0;
            m_start    <= 1'b0;
            m_addr     <= 7'd0;
            m_rw       <= 1'b0;
            m_wdata    <= 8'd0;
        end else begin
            done <= 2'b00;
            err  <= 2'b00;
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        gnt     <= pick;
                        m_addr  <= pick ? addr[13:7]  : addr[6:0];
                        m_rw    <= pick ? rw[1]       : rw[0];
                        m_wdata <= pick ? wdata[15:8] : wdata[7:0];
                        m_start <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    m_start <= 1'b0;
                    timer   <= 16'd0;
                    state   <= WAIT;
                end
                WAIT: begin
                    // A completion in the same cycle as the timeout takes priority.
                    if (m_done) begin
                        rdata <= m_rdata;
                        done  <= gnt ? 2'b10 : 2'b01;
                        err   <= m_nack ? (gnt ? 2'b10 : 2'b01) : 2'b00;
                        state <= RESP;
                    end else if (timer == TIMEOUT) begin
                        done  <= gnt ? 2'b10 : 2'b01;
                        err   <= gnt ? 2'b10 : 2'b01;
                        state <= RESP;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                RESP: begin
                    last_grant <= gnt;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Bench for i2c_arbiter: directed vector table, corner sequences, then random transactions
// checked against a transaction-level round-robin model.
module tb_i2c_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [13:0] addr;
    logic [1:0]  rw;
    logic [15:0] wdata;
    logic [1:0]  done;
    logic [1:0]  err;
    logic [7:0]  rdata;
    logic        busy;
    logic        m_start;
    logic [6:0]  m_addr;
    logic        m_rw;
    logic [7:0]  m_wdata;
    logic        m_done;
    logic [7:0]  m_rdata;
    logic        m_nack;

    int total = 0;
    int bad   = 0;

    i2c_arbiter #(.TIMEOUT(16'd16)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .addr    (addr),
        .rw      (rw),
        .wdata   (wdata),
        .done    (done),
        .err     (err),
        .rdata   (rdata),
        .busy    (busy),
        .m_start (m_start),
        .m_addr  (m_addr),
        .m_rw    (m_rw),
        .m_wdata (m_wdata),
        .m_done  (m_done),
        .m_rdata (m_rdata),
        .m_nack  (m_nack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  rq;
        logic [13:0] ad;
        logic [1:0]  rwv;
        logic [15:0] wd;
        int          d;
        logic        nk;
        logic [7:0]  md;
        logic [1:0]  rq_after;
        int          eg;
        logic        ee;
        logic [7:0]  erd;
        int          elat;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction from an IDLE cycle; d = WAIT cycles before m_done (>16 never pulses).
    task automatic run_txn(input vec_t v, input string nm);
        int         cnt;
        logic [6:0] ea;
        logic       erw;
        logic [7:0] ewd;
        ea  = (v.eg == 1) ? v.ad[13:7]  : v.ad[6:0];
        erw = (v.eg == 1) ? v.rwv[1]    : v.rwv[0];
        ewd = (v.eg == 1) ? v.wd[15:8]  : v.wd[7:0];
        req = v.rq; addr = v.ad; rw = v.rwv; wdata = v.wd;
        tick();
        chk({nm, "_start"}, {31'd0, m_start}, 32'd1);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
        chk({nm, "_cmd"}, {16'd0, m_addr, m_rw, m_wdata}, {16'd0, ea, erw, ewd});
        cnt = 0;
        while (done == 2'b00 && cnt < 40) begin
            m_done  = (cnt - 1 == v.d);
            m_rdata = v.md;
            m_nack  = v.nk;
            tick();
            cnt++;
            m_done = 1'b0;
            if (cnt == 1) chk({nm, "_start_1cyc"}, {31'd0, m_start}, 32'd0);
        end
        chk({nm, "_lat"}, cnt, v.elat);
        chk({nm, "_done"}, {30'd0, done}, (v.eg == 1) ? 32'd2 : 32'd1);
        chk({nm, "_err"}, {30'd0, err}, v.ee ? ((v.eg == 1) ? 32'd2 : 32'd1) : 32'd0);
        chk({nm, "_rdata"}, {24'd0, rdata}, {24'd0, v.erd});
        chk({nm, "_cmd_hold"}, {16'd0, m_addr, m_rw, m_wdata}, {16'd0, ea, erw, ewd});
        req = v.rq_after;
        tick();
        chk({nm, "_idle"}, {28'd0, done, err}, 32'd0);
        chk({nm, "_busy_off"}, {31'd0, busy}, 32'd0);
    endtask

    int         last_m;
    logic [7:0] rdata_m;

    initial begin
        vec_t v;
        tbl[0] = '{2'b01, {7'h00, 7'h51}, 2'b01, 16'h0000, 2,  1'b0, 8'hA5, 2'b00, 0, 1'b0, 8'hA5, 4};
        tbl[1] = '{2'b10, {7'h2C, 7'h00}, 2'b00, 16'h3C00, 0,  1'b1, 8'h77, 2'b00, 1, 1'b1, 8'h77, 2};
        tbl[2] = '{2'b01, {7'h00, 7'h33}, 2'b01, 16'h0000, 99, 1'b0, 8'h11, 2'b00, 0, 1'b1, 8'h77, 18};
        tbl[3] = '{2'b10, {7'h44, 7'h00}, 2'b10, 16'h0000, 16, 1'b0, 8'hC3, 2'b00, 1, 1'b0, 8'hC3, 18};
        tbl[4] = '{2'b11, {7'h2A, 7'h15}, 2'b10, 16'hBBAA, 1,  1'b0, 8'h01, 2'b11, 0, 1'b0, 8'h01, 3};
        tbl[5] = '{2'b11, {7'h2A, 7'h15}, 2'b10, 16'hBBAA, 3,  1'b0, 8'h02, 2'b11, 1, 1'b0, 8'h02, 5};
        tbl[6] = '{2'b11, {7'h2A, 7'h15}, 2'b10, 16'hBBAA, 0,  1'b0, 8'h03, 2'b11, 0, 1'b0, 8'h03, 2};
        tbl[7] = '{2'b11, {7'h2A, 7'h15}, 2'b10, 16'hBBAA, 5,  1'b0, 8'h04, 2'b00, 1, 1'b0, 8'h04, 7};

        reset = 1'b0; req = 2'b00; addr = 14'd0; rw = 2'b00; wdata = 16'd0;
        m_done = 1'b0; m_rdata = 8'd0; m_nack = 1'b0;
        tick();
        tick();
        chk("reset_outs", {5'd0, done, err, rdata, busy, m_start, m_addr, m_rw, m_wdata}, 32'd0);
        reset = 1'b1;
        tick();
        tick();
        chk("idle_no_req", {5'd0, done, err, busy, m_start}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i], $sformatf("vec%0d", i));
        end

        // m_done during ISSUE must be ignored.
        req = 2'b01; addr = {7'h00, 7'h10}; rw = 2'b01; wdata = 16'h0000;
        tick();
        m_done = 1'b1; m_rdata = 8'hEE; m_nack = 1'b1;
        tick();
        m_done = 1'b0; m_nack = 1'b0;
        chk("stray_busy", {31'd0, busy}, 32'd1);
        chk("stray_done", {30'd0, done}, 32'd0);
        tick();
        chk("stray_done2", {28'd0, done, err}, 32'd0);
        chk("stray_rdata", {24'd0, rdata}, 32'h04);
        m_done = 1'b1; m_rdata = 8'h42;
        tick();
        m_done = 1'b0;
        chk("stray_final_done", {28'd0, done, err}, 32'h4);
        chk("stray_final_rdata", {24'd0, rdata}, 32'h42);
        req = 2'b00;
        tick();

        // Reset mid-WAIT aborts silently.
        req = 2'b10; addr = {7'h55, 7'h00}; rw = 2'b10; wdata = 16'h9900;
        tick();
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_wait_outs", {5'd0, done, err, rdata, busy, m_start, m_addr, m_rw, m_wdata}, 32'd0);
        req = 2'b00;
        tick();
        tick();
        chk("rst_hold_outs", {5'd0, done, err, rdata, busy, m_start, m_addr, m_rw, m_wdata}, 32'd0);
        reset = 1'b1;
        tick();
        v = '{2'b10, {7'h5A, 7'h00}, 2'b10, 16'h6600, 1, 1'b0, 8'h3E, 2'b00, 1, 1'b0, 8'h3E, 3};
        run_txn(v, "post_rst");

        // Random transactions against the transaction-level model.
        last_m  = 1;
        rdata_m = 8'h3E;
        for (int n = 0; n < 60; n++) begin
            int g;
            v.rq  = 2'($urandom_range(1, 3));
            v.ad  = 14'($urandom);
            v.rwv = 2'($urandom);
            v.wd  = 16'($urandom);
            v.d   = $urandom_range(0, 20);
            v.nk  = 1'($urandom);
            v.md  = 8'($urandom);
            v.rq_after = ($urandom_range(0, 1) == 1) ? v.rq : 2'b00;
            if (v.rq == 2'b11) g = 1 - last_m;
            else               g = (v.rq == 2'b10) ? 1 : 0;
            v.eg = g;
            if (v.d <= 16) begin
                v.ee   = v.nk;
                rdata_m = v.md;
                v.elat = v.d + 2;
            end else begin
                v.ee   = 1'b1;
                v.elat = 18;
            end
            v.erd  = rdata_m;
            last_m = g;
            run_txn(v, $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
